// File: rtl/nios_mul_pkg.sv
// Shared definitions for the pipelined Nios multiply unit.
// Holds the operation encodings and small decode helpers that tell the
// combine stage which half to return and which operands are signed.
package nios_mul_pkg;

  localparam logic [1:0] MUL_OP_LO  = 2'b00;  // mul: low half
  localparam logic [1:0] MUL_OP_XUU = 2'b01;  // mulxuu: high half, unsigned x unsigned
  localparam logic [1:0] MUL_OP_XSU = 2'b10;  // mulxsu: high half, signed x unsigned
  localparam logic [1:0] MUL_OP_XSS = 2'b11;  // mulxss: high half, signed x signed

  // Every op except plain mul returns the upper DATA_W bits.
  function automatic logic op_is_high(input logic [1:0] op);
    return op != MUL_OP_LO;
  endfunction

  function automatic logic src1_signed(input logic [1:0] op);
    return (op == MUL_OP_XSU) || (op == MUL_OP_XSS);
  endfunction

  function automatic logic src2_signed(input logic [1:0] op);
    return op == MUL_OP_XSS;
  endfunction

endpackage

// File: rtl/nios_mul_pp_stage.sv
// First pipeline stage of the multiply unit: forms and registers the four
// HALF x HALF unsigned partial products together with op, tag and sources.
// Ports:
//   clk_i, reset_ni      clock, synchronous active-low reset
//   en_i                 stage advance; 0 holds every register
//   valid_i, op_i, src1_i, src2_i, tag_i   incoming operation
//   valid_o              stage valid bit
//   pp_ll_o..pp_hh_o     registered partial products (2*HALF bits each)
//   op_o, src1_o, src2_o, tag_o            registered sideband for the combine stage
module nios_mul_pp_stage
  import nios_mul_pkg::*;
#(
  parameter int unsigned HALF  = 16,
  parameter int unsigned TAG_W = 5
) (
  input  logic              clk_i,
  input  logic              reset_ni,
  input  logic              en_i,
  input  logic              valid_i,
  input  logic [1:0]        op_i,
  input  logic [2*HALF-1:0] src1_i,
  input  logic [2*HALF-1:0] src2_i,
  input  logic [TAG_W-1:0]  tag_i,
  output logic              valid_o,
  output logic [2*HALF-1:0] pp_ll_o,
  output logic [2*HALF-1:0] pp_lh_o,
  output logic [2*HALF-1:0] pp_hl_o,
  output logic [2*HALF-1:0] pp_hh_o,
  output logic [1:0]        op_o,
  output logic [2*HALF-1:0] src1_o,
  output logic [2*HALF-1:0] src2_o,
  output logic [TAG_W-1:0]  tag_o
);

  localparam int unsigned W = 2 * HALF;

  logic [W-1:0] a_lo, a_hi, b_lo, b_hi;
  logic [W-1:0] pp_ll_d, pp_lh_d, pp_hl_d, pp_hh_d;

  logic         valid_q;
  logic [W-1:0] pp_ll_q, pp_lh_q, pp_hl_q, pp_hh_q;
  logic [1:0]   op_q;
  logic [W-1:0] src1_q, src2_q;
  logic [TAG_W-1:0] tag_q;

  // Zero-extend halves to full width so each product keeps all 2*HALF bits.
  always_comb begin
    a_lo    = {{HALF{1'b0}}, src1_i[HALF-1:0]};
    a_hi    = {{HALF{1'b0}}, src1_i[W-1:HALF]};
    b_lo    = {{HALF{1'b0}}, src2_i[HALF-1:0]};
    b_hi    = {{HALF{1'b0}}, src2_i[W-1:HALF]};
    pp_ll_d = a_lo * b_lo;
    pp_lh_d = a_lo * b_hi;
    pp_hl_d = a_hi * b_lo;
    pp_hh_d = a_hi * b_hi;
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      valid_q <= 1'b0;
      pp_ll_q <= '0;
      pp_lh_q <= '0;
      pp_hl_q <= '0;
      pp_hh_q <= '0;
      op_q    <= MUL_OP_LO;
      src1_q  <= '0;
      src2_q  <= '0;
      tag_q   <= '0;
    end else if (en_i) begin
      valid_q <= valid_i;
      // Bubbles leave the data registers untouched.
      if (valid_i) begin
        pp_ll_q <= pp_ll_d;
        pp_lh_q <= pp_lh_d;
        pp_hl_q <= pp_hl_d;
        pp_hh_q <= pp_hh_d;
        op_q    <= op_i;
        src1_q  <= src1_i;
        src2_q  <= src2_i;
        tag_q   <= tag_i;
      end
    end
  end

  assign valid_o = valid_q;
  assign pp_ll_o = pp_ll_q;
  assign pp_lh_o = pp_lh_q;
  assign pp_hl_o = pp_hl_q;
  assign pp_hh_o = pp_hh_q;
  assign op_o    = op_q;
  assign src1_o  = src1_q;
  assign src2_o  = src2_q;
  assign tag_o   = tag_q;

endmodule

// File: rtl/nios_mul_pipe_unit.sv
// Pipelined integer multiply unit for the Nios-class datapath.
// Stage 1 (nios_mul_pp_stage) registers four unsigned half-width partial
// products; stage 2 sums them, applies signed corrections and selects the
// low or high product half; PIPE_EXTRA further register stages follow.
// Every stage advances only when en is high.
// Ports:
//   clk, reset_n      clock, synchronous active-low reset
//   en                global stage advance
//   in_valid, in_op, in_src1, in_src2, in_tag   operation input
//   out_valid, out_result, out_tag              result output
//   busy              any stage holds a valid operation
module nios_mul_pipe_unit
  import nios_mul_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned PIPE_EXTRA = 0,
  parameter int unsigned TAG_W      = 5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              en,
  input  logic              in_valid,
  input  logic [1:0]        in_op,
  input  logic [DATA_W-1:0] in_src1,
  input  logic [DATA_W-1:0] in_src2,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_result,
  output logic [TAG_W-1:0]  out_tag,
  output logic              busy
);

  localparam int unsigned HALF = DATA_W / 2;
  localparam int unsigned PW   = 2 * DATA_W;

  logic              pp_valid;
  logic [DATA_W-1:0] pp_ll, pp_lh, pp_hl, pp_hh;
  logic [1:0]        pp_op;
  logic [DATA_W-1:0] pp_src1, pp_src2;
  logic [TAG_W-1:0]  pp_tag;

  nios_mul_pp_stage #(
    .HALF  (HALF),
    .TAG_W (TAG_W)
  ) u_pp_stage (
    .clk_i    (clk),
    .reset_ni (reset_n),
    .en_i     (en),
    .valid_i  (in_valid),
    .op_i     (in_op),
    .src1_i   (in_src1),
    .src2_i   (in_src2),
    .tag_i    (in_tag),
    .valid_o  (pp_valid),
    .pp_ll_o  (pp_ll),
    .pp_lh_o  (pp_lh),
    .pp_hl_o  (pp_hl),
    .pp_hh_o  (pp_hh),
    .op_o     (pp_op),
    .src1_o   (pp_src1),
    .src2_o   (pp_src2),
    .tag_o    (pp_tag)
  );

  // Combine stage: full-width unsigned product, then two's-complement fixups.
  // A negative operand x contributes x_u - 2^DATA_W, so the cross term
  // -(other << DATA_W) is subtracted; the 2^(2*DATA_W) term vanishes mod PW.
  logic [PW-1:0]     sum;
  logic [PW-1:0]     prod;
  logic [DATA_W-1:0] res_d;

  always_comb begin
    sum = {{DATA_W{1'b0}}, pp_ll}
        + ({{DATA_W{1'b0}}, pp_lh} << HALF)
        + ({{DATA_W{1'b0}}, pp_hl} << HALF)
        + ({{DATA_W{1'b0}}, pp_hh} << DATA_W);
    prod = sum;
    if (src1_signed(pp_op) && pp_src1[DATA_W-1]) begin
      prod = prod - ({{DATA_W{1'b0}}, pp_src2} << DATA_W);
    end
    if (src2_signed(pp_op) && pp_src2[DATA_W-1]) begin
      prod = prod - ({{DATA_W{1'b0}}, pp_src1} << DATA_W);
    end
    res_d = op_is_high(pp_op) ? prod[PW-1:DATA_W] : prod[DATA_W-1:0];
  end

  // Index 0 is the combine-stage register; 1..PIPE_EXTRA are plain delay stages.
  logic [PIPE_EXTRA:0] v_q;
  logic [DATA_W-1:0]   res_q [PIPE_EXTRA+1];
  logic [TAG_W-1:0]    tag_q [PIPE_EXTRA+1];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      v_q <= '0;
      for (int unsigned i = 0; i <= PIPE_EXTRA; i++) begin
        res_q[i] <= '0;
        tag_q[i] <= '0;
      end
    end else if (en) begin
      v_q[0] <= pp_valid;
      if (pp_valid) begin
        res_q[0] <= res_d;
        tag_q[0] <= pp_tag;
      end
      for (int unsigned i = 1; i <= PIPE_EXTRA; i++) begin
        v_q[i] <= v_q[i-1];
        // Bubbles never overwrite the last valid result.
        if (v_q[i-1]) begin
          res_q[i] <= res_q[i-1];
          tag_q[i] <= tag_q[i-1];
        end
      end
    end
  end

  assign out_valid  = v_q[PIPE_EXTRA];
  assign out_result = res_q[PIPE_EXTRA];
  assign out_tag    = tag_q[PIPE_EXTRA];
  assign busy       = pp_valid | (|v_q);

endmodule

// File: tb/tb_nios_mul_pipe_unit.sv
// Scoreboard bench for nios_mul_pipe_unit. Two instances (PIPE_EXTRA=0 and
// PIPE_EXTRA=2) share one stimulus stream; each has its own expected queue.
module tb_nios_mul_pipe_unit;
  import nios_mul_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n, en, in_valid;
  logic [1:0]  in_op;
  logic [31:0] in_src1, in_src2;
  logic [4:0]  in_tag;

  logic        ov0, ov2, busy0, busy2;
  logic [31:0] res0, res2;
  logic [4:0]  tag0, tag2;

  nios_mul_pipe_unit #(.DATA_W(32), .PIPE_EXTRA(0), .TAG_W(5)) u_dut0 (
    .clk        (clk),
    .reset_n    (reset_n),
    .en         (en),
    .in_valid   (in_valid),
    .in_op      (in_op),
    .in_src1    (in_src1),
    .in_src2    (in_src2),
    .in_tag     (in_tag),
    .out_valid  (ov0),
    .out_result (res0),
    .out_tag    (tag0),
    .busy       (busy0)
  );

  nios_mul_pipe_unit #(.DATA_W(32), .PIPE_EXTRA(2), .TAG_W(5)) u_dut2 (
    .clk        (clk),
    .reset_n    (reset_n),
    .en         (en),
    .in_valid   (in_valid),
    .in_op      (in_op),
    .in_src1    (in_src1),
    .in_src2    (in_src2),
    .in_tag     (in_tag),
    .out_valid  (ov2),
    .out_result (res2),
    .out_tag    (tag2),
    .busy       (busy2)
  );

  typedef struct {
    logic [31:0] res;
    logic [4:0]  tag;
    int          due;
  } exp_t;

  exp_t q0[$];
  exp_t q2[$];

  int          tests_run    = 0;
  int          tests_failed = 0;
  int          en_edges     = 0;   // posedges taken with en=1 outside reset
  logic        last_en      = 1'b1;
  logic        last_rn      = 1'b0;
  logic        prev_ov  [2];
  logic [31:0] prev_res [2];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: sign/zero-extend to 64 bits and multiply directly.
  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [63:0] ae, be, p;
    ae = {32'b0, a};
    be = {32'b0, b};
    if (op == 2'b10 || op == 2'b11) ae = {{32{a[31]}}, a};
    if (op == 2'b11) be = {{32{b[31]}}, b};
    p = ae * be;
    return (op == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  task automatic monitor(input int idx, input logic ov, input logic [31:0] res,
                         input logic [4:0] tg, input logic bsy);
    exp_t  e;
    string nm;
    bit    empty;
    nm    = (idx == 0) ? "pe0" : "pe2";
    empty = (idx == 0) ? (q0.size() == 0) : (q2.size() == 0);
    if (!last_rn) begin
      check_eq({nm, "_rst_valid"}, 64'(ov), 64'd0);
      check_eq({nm, "_rst_result"}, 64'(res), 64'd0);
      check_eq({nm, "_rst_busy"}, 64'(bsy), 64'd0);
    end else if (!last_en) begin
      check_eq({nm, "_stall_valid"}, 64'(ov), 64'(prev_ov[idx]));
      check_eq({nm, "_stall_result"}, 64'(res), 64'(prev_res[idx]));
    end else if (ov) begin
      if (empty) begin
        check_eq({nm, "_spurious_valid"}, 64'(ov), 64'd0);
      end else begin
        if (idx == 0) e = q0.pop_front();
        else          e = q2.pop_front();
        check_eq({nm, "_result"}, 64'(res), 64'(e.res));
        check_eq({nm, "_tag"}, 64'(tg), 64'(e.tag));
        check_eq({nm, "_latency"}, 64'(en_edges), 64'(e.due));
        check_eq({nm, "_busy"}, 64'(bsy), 64'd1);
      end
    end else begin
      check_eq({nm, "_bubble_hold"}, 64'(res), 64'(prev_res[idx]));
    end
    prev_ov[idx]  = ov;
    prev_res[idx] = res;
  endtask

  // One cycle: check outputs of the previous edge, then drive the next inputs.
  task automatic tick(input logic rn, input logic e, input logic v, input logic [1:0] op,
                      input logic [31:0] a, input logic [31:0] b, input logic [4:0] tg,
                      input logic [31:0] exp_res);
    exp_t x;
    @(negedge clk);
    if (last_rn && last_en) en_edges++;
    monitor(0, ov0, res0, tag0, busy0);
    monitor(1, ov2, res2, tag2, busy2);
    reset_n  = rn;
    en       = e;
    in_valid = v;
    in_op    = op;
    in_src1  = a;
    in_src2  = b;
    in_tag   = tg;
    if (!rn) begin
      q0.delete();
      q2.delete();
    end else if (e && v) begin
      x.res = exp_res;
      x.tag = tg;
      x.due = en_edges + 2;
      q0.push_back(x);
      x.due = en_edges + 4;
      q2.push_back(x);
    end
    last_en = e;
    last_rn = rn;
  endtask

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] tg, input logic [31:0] exp_res);
    tick(1'b1, 1'b1, 1'b1, op, a, b, tg, exp_res);
  endtask

  task automatic idle();
    tick(1'b1, 1'b1, 1'b0, MUL_OP_LO, 32'h0, 32'h0, 5'd0, 32'h0);
  endtask

  // Stall cycle with a valid-looking op present that must not be captured.
  task automatic stall();
    tick(1'b1, 1'b0, 1'b1, MUL_OP_XSS, 32'hDEAD_BEEF, 32'h1234_5678, 5'd9, 32'h0);
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) idle();
    check_eq("drain_q0_empty", 64'(q0.size()), 64'd0);
    check_eq("drain_q2_empty", 64'(q2.size()), 64'd0);
  endtask

  initial begin
    logic [31:0] a, b;
    logic [1:0]  op;
    reset_n  = 1'b0;
    en       = 1'b1;
    in_valid = 1'b1;
    in_op    = MUL_OP_XUU;
    in_src1  = 32'hFFFF_FFFF;
    in_src2  = 32'hFFFF_FFFF;
    in_tag   = 5'd0;

    // Reset held with a valid op on the inputs.
    tick(1'b0, 1'b1, 1'b1, MUL_OP_XUU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0, 32'h0);
    tick(1'b0, 1'b1, 1'b1, MUL_OP_XUU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0, 32'h0);
    idle();
    idle();
    check_eq("release_valid0", 64'(ov0), 64'd0);
    check_eq("release_valid2", 64'(ov2), 64'd0);
    check_eq("release_busy0", 64'(busy0), 64'd0);
    check_eq("release_result0", 64'(res0), 64'd0);

    // Directed vectors.
    issue(MUL_OP_LO,  32'h0001_0003, 32'h0002_0005, 5'd1, 32'h000B_000F);
    issue(MUL_OP_XUU, 32'h0001_0003, 32'h0002_0005, 5'd2, 32'h0000_0002);
    issue(MUL_OP_XSS, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'h0000_0000);
    issue(MUL_OP_XUU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 32'hFFFF_FFFE);
    issue(MUL_OP_XSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5, 32'hFFFF_FFFF);
    issue(MUL_OP_XSS, 32'h8000_0000, 32'h8000_0000, 5'd6, 32'h4000_0000);
    issue(MUL_OP_LO,  32'h8000_0000, 32'h8000_0000, 5'd7, 32'h0000_0000);
    drain(6);

    // Stall after the second issue.
    issue(MUL_OP_XSU, 32'h8765_4321, 32'h1357_9BDF, 5'd1,
          model(MUL_OP_XSU, 32'h8765_4321, 32'h1357_9BDF));
    issue(MUL_OP_LO, 32'hCAFE_F00D, 32'h0BAD_C0DE, 5'd2,
          model(MUL_OP_LO, 32'hCAFE_F00D, 32'h0BAD_C0DE));
    stall();
    stall();
    stall();
    issue(MUL_OP_XSS, 32'hFFFF_0001, 32'h7FFF_FFFF, 5'd3,
          model(MUL_OP_XSS, 32'hFFFF_0001, 32'h7FFF_FFFF));
    stall();
    idle();
    stall();
    drain(6);

    // Random mix of ops, bubbles and stalls.
    for (int i = 0; i < 60; i++) begin
      a  = $urandom();
      b  = $urandom();
      op = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 5))
        0:       stall();
        1:       idle();
        default: issue(op, a, b, 5'(i), model(op, a, b));
      endcase
    end
    drain(8);

    // Reset with two ops in flight.
    issue(MUL_OP_XUU, 32'h1111_1111, 32'h2222_2222, 5'd10,
          model(MUL_OP_XUU, 32'h1111_1111, 32'h2222_2222));
    issue(MUL_OP_LO, 32'h3333_3333, 32'h4444_4444, 5'd11,
          model(MUL_OP_LO, 32'h3333_3333, 32'h4444_4444));
    tick(1'b0, 1'b1, 1'b0, MUL_OP_LO, 32'h0, 32'h0, 5'd0, 32'h0);
    idle();
    idle();
    idle();
    idle();
    check_eq("midrst_busy0", 64'(busy0), 64'd0);
    check_eq("midrst_busy2", 64'(busy2), 64'd0);
    issue(MUL_OP_XSU, 32'hF000_0000, 32'h0000_0010, 5'd12,
          model(MUL_OP_XSU, 32'hF000_0000, 32'h0000_0010));
    drain(6);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
